// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a count-prefixed big-endian byte
// stream, writes 32-bit words to sequential addresses and holds the CPU until done.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        ImWrEn,
  output logic [31:0] ImWrAddr,
  output logic [31:0] ImWrData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error,
  output logic [15:0] WordsLoaded,
  output logic [2:0]  DbgState
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_e      state_q;
  logic [15:0] n_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_idx_q;
  logic [31:0] asm_q;
  logic        wr_pend_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        hold_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] words_q;

  logic        transfer;
  logic [15:0] n_d;
  logic [31:0] asm_d;
  logic [15:0] word_idx_d;

  // Handshake: a byte moves on a rising edge where ByteValid and ByteReady are
  // both high; ByteReady drops for the single write cycle after each 4th byte.
  assign ByteReady  = ((state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                       (state_q == S_DATA)) && !wr_pend_q;
  assign transfer   = ByteValid && ByteReady;
  assign n_d        = {n_q[15:8], ByteIn};
  assign asm_d      = {asm_q[23:0], ByteIn};
  assign word_idx_d = word_idx_q + 16'd1;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      wr_pend_q  <= 1'b0;
      addr_q     <= BASE_ADDR;
      data_q     <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      words_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_HDR_HI;
        S_HDR_HI: begin
          if (transfer) begin
            n_q     <= {ByteIn, 8'h00};
            state_q <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (transfer) begin
            n_q <= n_d;
            if ((n_d == 16'd0) || ({1'b0, n_d} > MAX_W)) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else begin
              state_q    <= S_DATA;
              byte_idx_q <= '0;
              word_idx_q <= '0;
            end
          end
        end
        S_DATA: begin
          if (wr_pend_q) begin
            wr_pend_q  <= 1'b0;
            word_idx_q <= word_idx_d;
            words_q    <= words_q + 16'd1;
            if (word_idx_d == n_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end
          end else if (transfer) begin
            asm_q      <= asm_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              wr_pend_q <= 1'b1;
              data_q    <= asm_d;
              addr_q    <= BASE_ADDR + {14'b0, word_idx_q, 2'b00};
            end
          end
        end
        S_DONE, S_ERROR: begin
          // Re-arm skips IDLE; address/data keep their last written values.
          if (Start) begin
            state_q    <= S_HDR_HI;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            n_q        <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ImWrEn      = wr_pend_q;
  assign ImWrAddr    = addr_q;
  assign ImWrData    = data_q;
  assign CpuHold     = hold_q;
  assign Done        = done_q;
  assign Error       = error_q;
  assign WordsLoaded = words_q;
  assign DbgState    = state_q;

endmodule
